// File: rtl/dcache_line_mover_pkg.sv
// Shared constants, FSM state encoding and address helper for the dcache line mover.
package dcache_line_mover_pkg;

    localparam int LINE_WORDS = 16;
    localparam int OFFSET_W   = 4;
    localparam int INDEX_W    = 8;
    localparam int TAG_W      = 18;
    localparam int RAM_ADDR_W = INDEX_W + OFFSET_W;
    localparam int WORD_W     = 32;
    localparam int FIFO_W     = WORD_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB_ADDR = 3'd1,
        ST_WB_DATA = 3'd2,
        ST_WB_RESP = 3'd3,
        ST_RF_ADDR = 3'd4,
        ST_RF_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Byte address of the first word of a line: {tag, index, word offset, byte offset}
    function automatic logic [WORD_W-1:0] burst_addr(input logic [TAG_W-1:0]   tag,
                                                     input logic [INDEX_W-1:0] index);
        return {tag, index, 6'b0};
    endfunction

endpackage

// File: rtl/dcache_line_mover_wb_fifo.sv
// Two-entry FIFO decoupling SRAM read data from the writeback burst handshake.
module dcache_line_mover_wb_fifo
    import dcache_line_mover_pkg::*;
#(
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;

    // Pointers and occupancy; the caller never pushes when full or pops when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is data only and needs no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/dcache_line_mover.sv
// Refill/writeback engine between the dcache miss FSM, the 2-way data SRAM and the burst bus.
module dcache_line_mover
    import dcache_line_mover_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_way,
    input  logic [INDEX_W-1:0]    req_index,
    input  logic                  req_dirty,
    input  logic [TAG_W-1:0]      req_victim_tag,
    input  logic [TAG_W-1:0]      req_refill_tag,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [1:0]            ram_en,
    output logic [7:0]            ram_wen,
    output logic [WORD_W-1:0]     ram_data0_w,
    output logic [WORD_W-1:0]     ram_data1_w,
    input  logic [WORD_W-1:0]     ram_data0_o,
    input  logic [WORD_W-1:0]     ram_data1_o,
    output logic                  wr_req,
    output logic [WORD_W-1:0]     wr_addr,
    input  logic                  wr_ack,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  wr_data_valid,
    output logic                  wr_data_last,
    input  logic                  wr_data_ready,
    input  logic                  wr_resp,
    output logic                  rd_req,
    output logic [WORD_W-1:0]     rd_addr,
    input  logic                  rd_ack,
    input  logic [WORD_W-1:0]     rd_data,
    input  logic                  rd_data_valid,
    input  logic                  rd_data_last
);

    state_t               state_q, state_d;
    logic                 way_q;
    logic [INDEX_W-1:0]   index_q;
    logic [TAG_W-1:0]     victim_tag_q;
    logic [TAG_W-1:0]     refill_tag_q;
    logic [OFFSET_W:0]    rd_cnt_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [OFFSET_W-1:0]  wr_ptr_q;
    logic                 err_q;

    logic                 accept;
    logic                 rd_issue;
    logic                 fifo_pop;
    logic                 rf_write;
    logic                 rf_err;
    logic [1:0]           way_sel;
    logic [FIFO_W-1:0]    fifo_head;
    logic [FIFO_W-1:0]    fifo_push_data;
    logic [1:0]           fifo_count;

    assign accept  = req_valid && req_ready;
    assign way_sel = way_q ? 2'b10 : 2'b01;

    // The read issued last cycle returns now; tag it with its last-word marker
    assign fifo_push_data = {inflight_last_q, (way_q ? ram_data1_o : ram_data0_o)};

    dcache_line_mover_wb_fifo #(
        .WIDTH(FIFO_W)
    ) u_wb_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // Control state: FSM, word counters, read-in-flight tracking, framing error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            way_q           <= 1'b0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (rd_cnt_q[OFFSET_W-1:0] == 4'hF);
            if (accept) begin
                way_q    <= req_way;
                rd_cnt_q <= '0;
                wr_ptr_q <= '0;
                err_q    <= 1'b0;
            end
            if (rd_issue) rd_cnt_q <= rd_cnt_q + 5'd1;
            if (rf_write) wr_ptr_q <= wr_ptr_q + 4'd1;
            if (rf_err)   err_q    <= 1'b1;
        end
    end

    // Request fields are plain data: captured on accept, never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            index_q      <= req_index;
            victim_tag_q <= req_victim_tag;
            refill_tag_q <= req_refill_tag;
        end
    end

    // Next state and all outputs; everything idles at 0 outside its own state
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        done_valid    = 1'b0;
        done_err      = 1'b0;
        ram_addr      = '0;
        ram_en        = 2'b00;
        ram_wen       = 8'h00;
        ram_data0_w   = '0;
        ram_data1_w   = '0;
        wr_req        = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        wr_data_valid = 1'b0;
        wr_data_last  = 1'b0;
        rd_req        = 1'b0;
        rd_addr       = '0;
        rd_issue      = 1'b0;
        fifo_pop      = 1'b0;
        rf_write      = 1'b0;
        rf_err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_dirty ? ST_WB_ADDR : ST_RF_ADDR;
            end
            ST_WB_ADDR: begin
                wr_req  = 1'b1;
                wr_addr = burst_addr(victim_tag_q, index_q);
                if (wr_ack) state_d = ST_WB_DATA;
            end
            ST_WB_DATA: begin
                // Reads in flight plus buffered words never exceed the two FIFO slots
                rd_issue = (rd_cnt_q < 5'(LINE_WORDS)) &&
                           ((fifo_count + {1'b0, inflight_q}) < 2'd2);
                if (rd_issue) begin
                    ram_en   = way_sel;
                    ram_addr = {index_q, rd_cnt_q[OFFSET_W-1:0]};
                end
                wr_data_valid = (fifo_count != 2'd0);
                if (wr_data_valid) begin
                    wr_data      = fifo_head[WORD_W-1:0];
                    wr_data_last = fifo_head[WORD_W];
                end
                fifo_pop = wr_data_valid && wr_data_ready;
                if (fifo_pop && fifo_head[WORD_W]) state_d = ST_WB_RESP;
            end
            ST_WB_RESP: begin
                if (wr_resp) state_d = ST_RF_ADDR;
            end
            ST_RF_ADDR: begin
                rd_req  = 1'b1;
                rd_addr = burst_addr(refill_tag_q, index_q);
                if (rd_ack) state_d = ST_RF_DATA;
            end
            ST_RF_DATA: begin
                if (rd_data_valid) begin
                    rf_write = 1'b1;
                    ram_en   = way_sel;
                    ram_addr = {index_q, wr_ptr_q};
                    if (way_q) begin
                        ram_wen     = 8'hF0;
                        ram_data1_w = rd_data;
                    end else begin
                        ram_wen     = 8'h0F;
                        ram_data0_w = rd_data;
                    end
                    // Finish on the first last marker or after word 15, whichever comes first
                    if (rd_data_last || (wr_ptr_q == 4'hF)) begin
                        state_d = ST_DONE;
                        rf_err  = !(rd_data_last && (wr_ptr_q == 4'hF));
                    end
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
